mpadd_seq: RTL and testbench
============================

Name: mpadd_seq

Overview:
- Multi-precision add/subtract sequencer built around one instance of the team's 16-bit carry-lookahead adder (cla_16bits).
- Processes WORDS x 16-bit operands one slice per cycle, least significant slice first, chaining the carry through a register.
- Presents a valid/ready command interface and a valid/ready result interface.
- Used where wide (e.g. 64-bit) arithmetic is needed without instantiating a wide adder.

Parameters:
- WIDTH, 16, slice width; must equal the cla_16bits width, other values unsupported.
- WORDS, 4, number of slices; total operand width N = WIDTH*WORDS; legal range 2..16.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start_valid  input  1  command valid.
- start_ready  output  1  command accepted when start_valid && start_ready at a clk edge.
- op_a  input  N  operand A, captured at acceptance.
- op_b  input  N  operand B, captured at acceptance.
- sub  input  1  0: A+B, 1: A-B; captured at acceptance.
- res_valid  output  1  result valid.
- res_ready  input  1  result consumed when res_valid && res_ready at a clk edge.
- result  output  N  sum/difference, modulo 2^N.
- cout  output  1  raw carry out of the MSB slice; for subtract, 1 = no borrow.
- overflow  output  1  two's-complement signed overflow.
- busy  output  1  high in RUN.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: state=IDLE, slice counter=0, carry reg=0, result=0, cout=0, overflow=0, res_valid=0, busy=0, start_ready=1 (IDLE).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On acceptance: register op_a, op_b and sub; carry reg <= sub; counter <= 0; go to RUN.
- RUN, per cycle with counter k:
  - Adder A = A_reg[k*16+:16].
  - Adder B = B_reg slice, bitwise inverted when sub=1.
  - Adder Cin = carry reg.
  - At the edge: result[k*16+:16] <= adder S; carry reg <= adder Cout; k++.
  - At k=WORDS-1, additionally:
    - cout <= adder Cout.
    - overflow <= (A_msb == B'_msb) && (S_msb != A_msb), where B' is the post-inversion operand.
    - Go to DONE.
  - start_ready=0 throughout RUN.
- Latency: exactly WORDS cycles. Command accepted at edge T; res_valid=1 after edge T+WORDS.
- DONE:
  - res_valid=1. result, cout and overflow are held stable until the result is consumed.
  - start_ready = res_ready, so back-to-back operation is allowed.
  - res_valid && res_ready && start_valid: consume the result and accept the new command at the same edge; go to RUN.
  - res_valid && res_ready && !start_valid: go to IDLE; res_valid <= 0. result and flags keep their last values.
  - !res_ready: remain in DONE.
- Operand inputs are ignored except at acceptance; changes during RUN or DONE have no effect.
- Reset asserted mid-operation (any state): all outputs take their reset values immediately and the in-flight command is discarded. No res_valid appears after reset release until a new command completes.
- start_valid while start_ready=0: ignored. No queuing; the requester must hold start_valid.

Optional Feature:
- Macro: MPADD_SAT_EN.
- Defined:
  - At the final slice, if the computed overflow=1, result is replaced by signed saturation.
    - Positive overflow (A_msb=0): 0x7FF..F.
    - Negative overflow (A_msb=1): 0x800..0.
  - overflow still reports 1; cout reports the raw adder carry.
  - Replacing the result adds no cycles; latency stays WORDS.
- Undefined: the result wraps modulo 2^N; no saturation logic is present.

Test Plan (WORDS=4, N=64):
- Add, carry into slice 1: A=0x0000_0000_0000_FFFF, B=1, sub=0 -> result=0x0000_0000_0001_0000, cout=0, overflow=0. res_valid rises exactly 4 cycles after acceptance; busy high for those 4 cycles.
- Full carry ripple: A=0xFFFF_FFFF_FFFF_FFFF, B=1, sub=0 -> result=0, cout=1, overflow=0.
- Signed overflow: A=0x7FFF_FFFF_FFFF_FFFF, B=1, sub=0 -> overflow=1, cout=0. Without MPADD_SAT_EN, result=0x8000_0000_0000_0000; with it, result=0x7FFF_FFFF_FFFF_FFFF.
- Subtract with borrow: A=0, B=1, sub=1 -> result=0xFFFF_FFFF_FFFF_FFFF, cout=0, overflow=0. Also A=5, B=3, sub=1 -> result=2, cout=1.
- Backpressure and back-to-back:
  - Hold res_ready=0 for 5 cycles in DONE -> res_valid, result and flags stable; start_ready=0; a pulsed start_valid is not accepted.
  - Then raise res_ready with start_valid=1 -> both handshakes at the same edge; the next res_valid follows 4 cycles later.
- Reset mid-run: assert rst_n=0 during RUN slice k=2 -> res_valid=0, busy=0, result=0 asynchronously. After release, start_ready=1 and no result is produced until a new command completes.

Source files
------------

// File: rtl/mpadd_seq.sv
// Multi-precision add/subtract sequencer: one 16-bit CLA slice per cycle, LS slice first.
// Optional signed saturation of the final result when MPADD_SAT_EN is defined.

module cla_16bits (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout
);
  logic [15:0] g, p, c;
  logic [3:0]  gg, gp;
  logic [4:0]  gc;

  assign g = a & b;
  assign p = a ^ b;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_grp
      assign gp[gi] = &p[gi*4 +: 4];
      assign gg[gi] = g[gi*4+3] | (p[gi*4+3] & g[gi*4+2])
                    | (p[gi*4+3] & p[gi*4+2] & g[gi*4+1])
                    | (p[gi*4+3] & p[gi*4+2] & p[gi*4+1] & g[gi*4]);
      // Bit carries inside a group are expanded from the group carry-in, not chained.
      assign c[gi*4]   = gc[gi];
      assign c[gi*4+1] = g[gi*4] | (p[gi*4] & gc[gi]);
      assign c[gi*4+2] = g[gi*4+1] | (p[gi*4+1] & g[gi*4]) | (p[gi*4+1] & p[gi*4] & gc[gi]);
      assign c[gi*4+3] = g[gi*4+2] | (p[gi*4+2] & g[gi*4+1]) | (p[gi*4+2] & p[gi*4+1] & g[gi*4])
                       | (p[gi*4+2] & p[gi*4+1] & p[gi*4] & gc[gi]);
    end
  endgenerate

  assign gc[0] = cin;
  assign gc[1] = gg[0] | (gp[0] & cin);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0]) | (gp[2] & gp[1] & gp[0] & cin);
  assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1]) | (gp[3] & gp[2] & gp[1] & gg[0])
               | (gp[3] & gp[2] & gp[1] & gp[0] & cin);

  assign s    = p ^ c;
  assign cout = gc[4];
endmodule

module mpadd_seq #(
  parameter int WIDTH = 16,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic [WIDTH*WORDS-1:0] op_a,
  input  logic [WIDTH*WORDS-1:0] op_b,
  input  logic                   sub,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [WIDTH*WORDS-1:0] result,
  output logic                   cout,
  output logic                   overflow,
  output logic                   busy
);
  localparam int CW = $clog2(WORDS);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_reg, state_next;

  logic [CW-1:0]    cnt_reg;
  logic             carry_reg, sub_reg, cout_reg, ovf_reg;
  logic [WIDTH-1:0] a_words [WORDS];
  logic [WIDTH-1:0] b_words [WORDS];
  logic [WIDTH-1:0] res_words_reg [WORDS];
  logic [WIDTH*WORDS-1:0] a_reg, b_reg;

  logic [WIDTH-1:0] a_slice, b_slice, sum;
  logic             c_out, last, accept, ovf_calc;

  genvar gi;
  generate
    for (gi = 0; gi < WORDS; gi++) begin : g_words
      assign a_words[gi] = a_reg[gi*WIDTH +: WIDTH];
      assign b_words[gi] = b_reg[gi*WIDTH +: WIDTH];
      assign result[gi*WIDTH +: WIDTH] = res_words_reg[gi];
    end
  endgenerate

  assign a_slice  = a_words[cnt_reg];
  assign b_slice  = b_words[cnt_reg] ^ {WIDTH{sub_reg}};
  assign last     = (cnt_reg == CW'(WORDS - 1));
  assign accept   = start_valid && start_ready;
  assign ovf_calc = (a_slice[WIDTH-1] == b_slice[WIDTH-1]) && (sum[WIDTH-1] != a_slice[WIDTH-1]);

  cla_16bits u_cla (
    .a    (a_slice),
    .b    (b_slice),
    .cin  (carry_reg),
    .s    (sum),
    .cout (c_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    start_ready = 1'b0;
    res_valid   = 1'b0;
    busy        = 1'b0;
    case (state_reg)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        res_valid   = 1'b1;
        start_ready = res_ready;
        if (res_ready) state_next = start_valid ? RUN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg   <= '0;
      carry_reg <= 1'b0;
      sub_reg   <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      for (int i = 0; i < WORDS; i++) res_words_reg[i] <= '0;
    end else if (accept) begin
      a_reg     <= op_a;
      b_reg     <= op_b;
      sub_reg   <= sub;
      carry_reg <= sub;  // carry-in of 1 completes the two's complement of B
      cnt_reg   <= '0;
    end else if (state_reg == RUN) begin
      res_words_reg[cnt_reg] <= sum;
      carry_reg <= c_out;
      cnt_reg   <= cnt_reg + 1'b1;
      if (last) begin
        cout_reg <= c_out;
        ovf_reg  <= ovf_calc;
`ifdef MPADD_SAT_EN
        if (ovf_calc) begin
          for (int i = 0; i < WORDS - 1; i++) res_words_reg[i] <= {WIDTH{~a_slice[WIDTH-1]}};
          res_words_reg[WORDS-1] <= {a_slice[WIDTH-1], {(WIDTH-1){~a_slice[WIDTH-1]}}};
        end
`endif
      end
    end
  end

  assign cout     = cout_reg;
  assign overflow = ovf_reg;
endmodule

// File: tb/tb_mpadd_seq.sv
// Directed bench for mpadd_seq (WORDS=4): latency, carry/borrow, overflow, backpressure, async reset.
// Saturation expectations follow MPADD_SAT_EN.

module tb_mpadd_seq;
  logic        clk, rst_n, start_valid, start_ready, sub;
  logic        res_valid, res_ready, cout, overflow, busy;
  logic [63:0] op_a, op_b, result;

  int n_checks = 0;
  int n_fails  = 0;

  mpadd_seq #(.WIDTH(16), .WORDS(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .op_a        (op_a),
    .op_b        (op_b),
    .sub         (sub),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .result      (result),
    .cout        (cout),
    .overflow    (overflow),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b, input logic s,
                        input logic [63:0] er, input logic ec, input logic eo);
    chk({tag, "_start_ready"}, 64'(start_ready), 64'd1);
    start_valid = 1'b1; op_a = a; op_b = b; sub = s;
    tick();
    start_valid = 1'b0; op_a = ~a; op_b = ~b; sub = ~s;
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_busy"}, 64'(busy), 64'd1);
      chk({tag, "_valid_early"}, 64'(res_valid), 64'd0);
      tick();
    end
    chk({tag, "_valid"}, 64'(res_valid), 64'd1);
    chk({tag, "_busy_done"}, 64'(busy), 64'd0);
    chk({tag, "_result"}, result, er);
    chk({tag, "_cout"}, 64'(cout), 64'(ec));
    chk({tag, "_overflow"}, 64'(overflow), 64'(eo));
    $display("txn %s a=%h b=%h sub=%0d -> result=%h cout=%0d overflow=%0d", tag, a, b, s, result, cout, overflow);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_consumed"}, 64'(res_valid), 64'd0);
    chk({tag, "_held_result"}, result, er);
  endtask

  logic [63:0] sat_exp;

  initial begin
`ifdef MPADD_SAT_EN
    sat_exp = 64'h7FFF_FFFF_FFFF_FFFF;
`else
    sat_exp = 64'h8000_0000_0000_0000;
`endif
    rst_n = 1'b0; start_valid = 1'b0; res_ready = 1'b0; sub = 1'b0;
    op_a = '0; op_b = '0;
    tick(); tick();
    chk("rst_valid", 64'(res_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_start_ready", 64'(start_ready), 64'd1);
    chk("rst_result", result, 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    rst_n = 1'b1;
    tick();

    run_op("carry1", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0);
    run_op("ripple", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0);
    run_op("sovf",   64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, sat_exp, 1'b0, 1'b1);
    run_op("borrow", 64'd0, 64'd1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    run_op("sub53",  64'd5, 64'd3, 1'b1, 64'd2, 1'b1, 1'b0);

    // Backpressure: hold the result for 5 cycles, then back-to-back handshake.
    start_valid = 1'b1; op_a = 64'h1234_5678_9ABC_DEF0; op_b = 64'h0FED_CBA9_8765_4321; sub = 1'b0;
    tick();
    start_valid = 1'b0;
    repeat (4) tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(res_valid), 64'd1);
      chk("bp_result", result, 64'h2222_2222_2222_2211);
      chk("bp_cout", 64'(cout), 64'd0);
      chk("bp_overflow", 64'(overflow), 64'd0);
      chk("bp_start_ready", 64'(start_ready), 64'd0);
      if (i == 2) begin
        start_valid = 1'b1; op_a = 64'hDEAD; op_b = 64'hBEEF; sub = 1'b1;
      end
      tick();
      start_valid = 1'b0;
    end
    chk("bp_still_valid", 64'(res_valid), 64'd1);
    chk("bp_still_result", result, 64'h2222_2222_2222_2211);
    $display("txn backpressure result=%h cout=%0d overflow=%0d", result, cout, overflow);
    res_ready = 1'b1; start_valid = 1'b1; op_a = 64'd5; op_b = 64'd3; sub = 1'b1;
    #1;
    chk("b2b_start_ready", 64'(start_ready), 64'd1);
    tick();
    res_ready = 1'b0; start_valid = 1'b0; op_a = '0; op_b = '0; sub = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("b2b_busy", 64'(busy), 64'd1);
      chk("b2b_valid_early", 64'(res_valid), 64'd0);
      tick();
    end
    chk("b2b_valid", 64'(res_valid), 64'd1);
    chk("b2b_result", result, 64'd2);
    chk("b2b_cout", 64'(cout), 64'd1);
    $display("txn back_to_back result=%h cout=%0d overflow=%0d", result, cout, overflow);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // Asynchronous reset while slice k=2 is being processed.
    start_valid = 1'b1; op_a = 64'h1111_1111_1111_1111; op_b = 64'h1111_1111_1111_1111; sub = 1'b0;
    tick();
    start_valid = 1'b0;
    tick(); tick();
    chk("mid_result_partial", result, 64'h0000_0000_2222_2222);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(res_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_result", result, 64'd0);
    chk("mid_rst_start_ready", 64'(start_ready), 64'd1);
    tick(); tick();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("post_rst_no_valid", 64'(res_valid), 64'd0);
      chk("post_rst_busy", 64'(busy), 64'd0);
    end
    $display("txn mid_run_reset result=%h res_valid=%0d", result, res_valid);
    run_op("recover", 64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111, 1'b0,
           64'h2222_2222_2222_2222, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
